hamming_enc_seq: RTL and testbench

HAMMING_ENC_SEQ -- requirements
Module: hamming_enc_seq

---
 rtl/hamming_enc_seq.sv | 175 +++++++++++++++++
 tb/tb_hamming_enc_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_enc_seq.sv
// Sequential Hamming(16,11) SECDED encoder over a byte-wide data memory.
// Define HAMSEQ_READBACK_EN to re-read each encoded pair and flag mismatches on err.
module hamming_enc_seq #(
    parameter int MSG_COUNT = 15,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    input  logic [7:0] mem_rd_data,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
`ifdef HAMSEQ_READBACK_EN
        VF_LO,
        VF_HI,
`endif
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [11:1] data_q, data_d;

    logic [7:0]  src_lo, src_hi;
    logic [7:0]  dst_lo, dst_hi;
    logic        last;

    logic        p8, p4, p2, p1, p0;
    logic [7:0]  enc_lo, enc_hi;

    // Byte pair addresses for the current message index, modulo 256.
    assign src_lo = 8'(SRC_BASE) + {idx_q[6:0], 1'b0};
    assign src_hi = src_lo + 8'd1;
    assign dst_lo = 8'(DST_BASE) + {idx_q[6:0], 1'b0};
    assign dst_hi = dst_lo + 8'd1;
    assign last   = (idx_q == 8'(MSG_COUNT - 1));

    always_comb begin
        p8 = ^data_q[11:5];
        p4 = (^data_q[11:8]) ^ (^data_q[4:2]);
        p2 = data_q[11] ^ data_q[10] ^ data_q[7] ^ data_q[6]
           ^ data_q[4] ^ data_q[3] ^ data_q[1];
        p1 = data_q[11] ^ data_q[9] ^ data_q[7] ^ data_q[5]
           ^ data_q[4] ^ data_q[2] ^ data_q[1];
        p0 = (^data_q) ^ p8 ^ p4 ^ p2 ^ p1;
        enc_lo = {data_q[4], data_q[3], data_q[2], p4,
                  data_q[1], p2, p1, p0};
        enc_hi = {data_q[11:5], p8};
    end

`ifdef HAMSEQ_READBACK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        data_d      = data_q;
        mem_addr    = 8'd0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
`ifdef HAMSEQ_READBACK_EN
        err_d       = err_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD_LO;
                    idx_d   = 8'd0;
`ifdef HAMSEQ_READBACK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            RD_LO: begin
                mem_addr     = src_lo;
                data_d[8:1]  = mem_rd_data;
                state_d      = RD_HI;
            end
            RD_HI: begin
                mem_addr     = src_hi;
                data_d[11:9] = mem_rd_data[2:0];
                state_d      = WR_LO;
            end
            WR_LO: begin
                mem_addr    = dst_lo;
                mem_wr_en   = 1'b1;
                mem_wr_data = enc_lo;
                state_d     = WR_HI;
            end
            WR_HI: begin
                mem_addr    = dst_hi;
                mem_wr_en   = 1'b1;
                mem_wr_data = enc_hi;
`ifdef HAMSEQ_READBACK_EN
                state_d     = VF_LO;
`else
                if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD_LO;
                end
`endif
            end
`ifdef HAMSEQ_READBACK_EN
            VF_LO: begin
                mem_addr = dst_lo;
                if (mem_rd_data != enc_lo) begin
                    err_d = 1'b1;
                end
                state_d = VF_HI;
            end
            VF_HI: begin
                mem_addr = dst_hi;
                if (mem_rd_data != enc_hi) begin
                    err_d = 1'b1;
                end
                if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD_LO;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

`ifdef HAMSEQ_READBACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = (state_q != IDLE) && (state_q != DONE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Directed bench for hamming_enc_seq with a byte-wide memory model.
// Readback scenarios are compiled in when HAMSEQ_READBACK_EN is defined.
module tb_hamming_enc_seq;

`ifdef HAMSEQ_READBACK_EN
    localparam int CYC = 6;
`else
    localparam int CYC = 4;
`endif
    localparam int RUN     = CYC * 15;
    localparam int RST_AT  = CYC * 5;
    localparam int RUN_MAX = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, mem_wr_en, err;
    logic [7:0] mem_addr, mem_wr_data, mem_rd_data;

    logic [7:0] mem [0:255];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;
    logic       corrupt = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int cyc;
    logic [15:0] exp_w [0:14];

    hamming_enc_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .err        (err)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr]
        ^ ((corrupt && mem_addr == 8'd31) ? 8'h01 : 8'h00);

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
            chk("wr_when_idle", {31'd0, mem_wr_en & ~busy}, 32'd0);
        end
    end

    task automatic load(input int a, input logic [7:0] d);
        ld_addr = 8'(a);
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic set_msg(input int i, input logic [7:0] lo,
                           input logic [7:0] hi);
        load(2 * i, lo);
        load(2 * i + 1, hi);
    endtask

    task automatic fill_dst(input logic [7:0] v);
        for (int a = 30; a < 60; a++) load(a, v);
    endtask

    task automatic run(input int pulse_at, input int reset_at,
                       output int n);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        n = 0;
        while (n < RUN_MAX) begin
            @(posedge clk);
            n++;
            #1 start = (n == pulse_at);
            if (n == reset_at) begin
                reset = 1'b0;
                #1;
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_addr", {24'd0, mem_addr}, 32'd0);
                chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
                chk("rst_wr_data", {24'd0, mem_wr_data}, 32'd0);
                chk("rst_err", {31'd0, err}, 32'd0);
                return;
            end
            if (done) break;
        end
        start = 1'b0;
    endtask

    function automatic logic [15:0] enc(input logic [7:0] lo,
                                        input logic [7:0] hi);
        logic [11:1] d;
        logic q8, q4, q2, q1, q0;
        d  = {hi[2:0], lo};
        q8 = d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[11];
        q4 = d[2] ^ d[3] ^ d[4] ^ d[8] ^ d[9] ^ d[10] ^ d[11];
        q2 = d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[7] ^ d[10] ^ d[11];
        q1 = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[9] ^ d[11];
        q0 = q8 ^ q4 ^ q2 ^ q1;
        for (int k = 1; k <= 11; k++) q0 ^= d[k];
        return {d[11:5], q8, d[4], d[3], d[2], q4, d[1], q2, q1, q0};
    endfunction

    initial begin
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_addr", {24'd0, mem_addr}, 32'd0);
        chk("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
        chk("reset_wr_data", {24'd0, mem_wr_data}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk) reset = 1'b1;

        // all-zero messages
        for (int a = 0; a < 30; a++) load(a, 8'h00);
        fill_dst(8'hAA);
        run(0, 0, cyc);
        chk("zero_cycles", cyc, RUN);
        chk("zero_busy_end", {31'd0, busy}, 32'd0);
        for (int a = 30; a < 60; a++) chk($sformatf("zero_b%0d", a), {24'd0, mem[a]}, 32'd0);
        chk("zero_err", {31'd0, err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("done_level", {31'd0, done}, 32'd1);

        // directed vectors, restart from DONE, start pulse while busy
        set_msg(0, 8'h01, 8'h00);
        set_msg(1, 8'h00, 8'h04);
        set_msg(2, 8'hFF, 8'h07);
        set_msg(3, 8'h00, 8'hF8);
        fill_dst(8'hAA);
        run(10, 0, cyc);
        chk("vec_cycles", cyc, RUN);
        chk("vec_b30", {24'd0, mem[30]}, 32'h0F);
        chk("vec_b31", {24'd0, mem[31]}, 32'h00);
        chk("vec_b32", {24'd0, mem[32]}, 32'h17);
        chk("vec_b33", {24'd0, mem[33]}, 32'h81);
        chk("vec_b34", {24'd0, mem[34]}, 32'hFF);
        chk("vec_b35", {24'd0, mem[35]}, 32'hFF);
        chk("vec_b36", {24'd0, mem[36]}, 32'h00);
        chk("vec_b37", {24'd0, mem[37]}, 32'h00);
        for (int a = 38; a < 60; a++) chk($sformatf("vec_b%0d", a), {24'd0, mem[a]}, 32'd0);
        chk("vec_src0", {24'd0, mem[0]}, 32'h01);
        chk("vec_err", {31'd0, err}, 32'd0);

        // mid-run reset
        for (int i = 0; i < 15; i++) set_msg(i, 8'h01, 8'h00);
        fill_dst(8'hAA);
        run(0, RST_AT, cyc);
        repeat (4) @(posedge clk);
        #1 chk("rst_hold_addr", {24'd0, mem_addr}, 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int a = 30; a < 40; a += 2) begin
            chk($sformatf("rst_b%0d", a), {24'd0, mem[a]}, 32'h0F);
            chk($sformatf("rst_b%0d", a + 1), {24'd0, mem[a + 1]}, 32'h00);
        end
        for (int a = 40; a < 60; a++) chk($sformatf("rst_b%0d", a), {24'd0, mem[a]}, 32'hAA);

        // restart after reset
        run(0, 0, cyc);
        chk("rerun_cycles", cyc, RUN);
        for (int a = 30; a < 60; a += 2) begin
            chk($sformatf("rerun_b%0d", a), {24'd0, mem[a]}, 32'h0F);
            chk($sformatf("rerun_b%0d", a + 1), {24'd0, mem[a + 1]}, 32'h00);
        end

`ifdef HAMSEQ_READBACK_EN
        // corrupted readback of byte 31
        corrupt = 1'b1;
        run(0, 0, cyc);
        corrupt = 1'b0;
        chk("vf_cycles", cyc, RUN);
        chk("vf_err_set", {31'd0, err}, 32'd1);

        // random messages, clean readback
        for (int i = 0; i < 15; i++) begin
            logic [7:0] lo, hi;
            lo = 8'($urandom_range(0, 255));
            hi = 8'($urandom_range(0, 255));
            set_msg(i, lo, hi);
            exp_w[i] = enc(lo, hi);
        end
        run(0, 0, cyc);
        chk("rnd_cycles", cyc, RUN);
        chk("rnd_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 15; i++)
            chk($sformatf("rnd_w%0d", i), {16'd0, mem[31 + 2 * i], mem[30 + 2 * i]}, {16'd0, exp_w[i]});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
